// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle between the UART receiver and its controller/RX FIFO.
// slave: the receiver itself; master: the controller side that drives config and consumes results.
interface uart_receiver_if;
    logic       baud_rt_tick_i;
    logic       rx_i;
    logic [1:0] data_width_i;
    logic [1:0] stop_bits_i;
    logic [1:0] parity_mode_i;
    logic       rx_enable_i;
    logic [7:0] data_rx_o;
    logic       parity_o;
    logic       frame_error_o;
    logic       rx_done_o;
    logic       is_receiving_o;

    modport slave (
        input  baud_rt_tick_i,
        input  rx_i,
        input  data_width_i,
        input  stop_bits_i,
        input  parity_mode_i,
        input  rx_enable_i,
        output data_rx_o,
        output parity_o,
        output frame_error_o,
        output rx_done_o,
        output is_receiving_o
    );

    modport master (
        output baud_rt_tick_i,
        output rx_i,
        output data_width_i,
        output stop_bits_i,
        output parity_mode_i,
        output rx_enable_i,
        input  data_rx_o,
        input  parity_o,
        input  frame_error_o,
        input  rx_done_o,
        input  is_receiving_o
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled deserialiser for 5-8 data bits, optional parity, 1-2 stop bits.
// Reports raw data/parity/frame-error with a one-cycle write strobe; checking is done downstream.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            clk_i,
    input logic            rst_n_i,
    uart_receiver_if.slave bus
);
    localparam int unsigned     TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   LAST_CNT = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [TW-1:0]          tick_cnt;
    logic [2:0]             bit_cnt;
    logic [1:0]             width_q;
    logic [1:0]             stop_q;
    logic [1:0]             parity_q;
    logic [7:0]             data_sh;
    logic                   par_sh;
    logic                   fe_sh;
    logic                   mid_tick;
    logic                   end_tick;
    logic [2:0]             last_data_bit;
    logic                   two_stops;
    logic                   parity_en;

    assign rx_s          = sync_q[SYNC_STAGES-1];
    assign mid_tick      = bus.baud_rt_tick_i && (tick_cnt == MID_CNT);
    assign end_tick      = bus.baud_rt_tick_i && (tick_cnt == LAST_CNT);
    // width code 0..3 maps to 5..8 bits, so the last index is 4 + code
    assign last_data_bit = {1'b1, width_q};
    assign two_stops     = (stop_q == 2'b01);
    assign parity_en     = !parity_q[1];

    // Presets to idle-high so reset release never looks like a start bit; needs SYNC_STAGES >= 2.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= IDLE;
            tick_cnt           <= '0;
            bit_cnt            <= '0;
            width_q            <= '0;
            stop_q             <= '0;
            parity_q           <= '0;
            data_sh            <= '0;
            par_sh             <= 1'b0;
            fe_sh              <= 1'b0;
            bus.data_rx_o      <= '0;
            bus.parity_o       <= 1'b0;
            bus.frame_error_o  <= 1'b0;
            bus.rx_done_o      <= 1'b0;
            bus.is_receiving_o <= 1'b0;
        end else begin
            bus.rx_done_o <= 1'b0;
            if (bus.baud_rt_tick_i) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    bus.is_receiving_o <= 1'b0;
                    if (!rx_s && bus.rx_enable_i) begin
                        state              <= START;
                        tick_cnt           <= '0;
                        bit_cnt            <= '0;
                        data_sh            <= '0;
                        par_sh             <= 1'b0;
                        fe_sh              <= 1'b0;
                        bus.is_receiving_o <= 1'b1;
                    end
                end

                START: begin
                    if (mid_tick) begin
                        if (rx_s) begin
                            state              <= IDLE;
                            tick_cnt           <= '0;
                            bus.is_receiving_o <= 1'b0;
                        end else begin
                            width_q  <= bus.data_width_i;
                            stop_q   <= bus.stop_bits_i;
                            parity_q <= bus.parity_mode_i;
                        end
                    end else if (end_tick) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end

                DATA: begin
                    if (mid_tick) begin
                        data_sh[bit_cnt] <= rx_s;
                    end else if (end_tick) begin
                        tick_cnt <= '0;
                        if (bit_cnt == last_data_bit) begin
                            bit_cnt <= '0;
                            state   <= parity_en ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (mid_tick) begin
                        par_sh <= rx_s;
                    end else if (end_tick) begin
                        state    <= STOP;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end

                // Leaves at the mid-sample of the final stop bit so the next start edge is caught early.
                STOP: begin
                    if (mid_tick) begin
                        if (!rx_s) begin
                            fe_sh <= 1'b1;
                        end
                        if (!two_stops || bit_cnt[0]) begin
                            state    <= DONE;
                            tick_cnt <= '0;
                        end
                    end else if (end_tick) begin
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end

                DONE: begin
                    bus.data_rx_o      <= data_sh;
                    bus.parity_o       <= par_sh;
                    bus.frame_error_o  <= fe_sh;
                    bus.rx_done_o      <= 1'b1;
                    bus.is_receiving_o <= 1'b0;
                    tick_cnt           <= '0;
                    state              <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
